// File: rtl/sensor_scan_ctrl_pkg.sv
// Shared home-automation definitions: scan FSM encoding and sensor scan defaults.
package sensor_scan_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    NEXT   = 2'd3
  } scan_state_t;

  localparam int DWELL_DEF    = 4;
  localparam int DEBOUNCE_DEF = 3;
  localparam int NUM_CH       = 4;

endpackage

// File: rtl/sensor_scan_ctrl_mux4to1.sv
// Plain 4:1 bit multiplexer used to pick one raw sensor line.
module mux4to1 (
  input  logic [1:0] sel,
  input  logic [3:0] in,
  output logic       out
);

  assign out = in[sel];

endmodule

// File: rtl/sensor_scan_ctrl.sv
// Round-robin scanner for four raw sensor lines: settle, synchronise, debounce,
// and report per-channel flips plus an end-of-pass pulse.
module sensor_scan_ctrl
  import sensor_scan_ctrl_pkg::*;
#(
  parameter int DWELL    = DWELL_DEF,
  parameter int DEBOUNCE = DEBOUNCE_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [3:0] sensors,
  output logic [1:0] sel,
  output logic [3:0] state_q,
  output logic [3:0] change,
  output logic       scan_done,
  output logic       busy
);

  localparam logic [7:0] DWELL_LAST = 8'(DWELL - 1);
  localparam logic [3:0] DEB_N      = 4'(DEBOUNCE);

  scan_state_t st;
  logic [7:0]  dcnt;
  logic [3:0]  dbc [NUM_CH];
  logic [3:0]  dbc_inc;
  logic        mux_out;
  logic        sync_p0;
  logic        sync_p1;

  mux4to1 u_mux (
    .sel (sel),
    .in  (sensors),
    .out (mux_out)
  );

  // Stage p0/p1: two-flop synchroniser on the selected line
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= mux_out;
      sync_p1 <= sync_p0;
    end
  end

  assign dbc_inc = dbc[sel] + 4'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st        <= IDLE;
      sel       <= 2'd0;
      dcnt      <= 8'd0;
      state_q   <= 4'b0000;
      change    <= 4'b0000;
      scan_done <= 1'b0;
      busy      <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) dbc[i] <= 4'd0;
    end else begin
      change    <= 4'b0000;
      scan_done <= 1'b0;
      unique case (st)
        IDLE: begin
          if (en) begin
            sel  <= 2'd0;
            dcnt <= 8'd0;
            busy <= 1'b1;
            st   <= SETTLE;
          end
        end
        SETTLE: begin
          if (dcnt == DWELL_LAST) st <= SAMPLE;
          else                    dcnt <= dcnt + 8'd1;
        end
        SAMPLE: begin
          // Pulses are registered here so they appear during the following NEXT cycle
          if (sync_p1 == state_q[sel]) begin
            dbc[sel] <= 4'd0;
          end else if (dbc_inc == DEB_N) begin
            state_q[sel] <= ~state_q[sel];
            dbc[sel]     <= 4'd0;
            change[sel]  <= 1'b1;
          end else begin
            dbc[sel] <= dbc_inc;
          end
          if (sel == 2'd3) scan_done <= 1'b1;
          st <= NEXT;
        end
        NEXT: begin
          sel  <= sel + 2'd1;
          dcnt <= 8'd0;
          if (sel == 2'd3 && !en) begin
            busy <= 1'b0;
            st   <= IDLE;
          end else begin
            st <= SETTLE;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule
